// File: rtl/datamem_bytelane.sv
`default_nettype none
// ============================================================================
// Module   : datamem_bytelane
// Purpose  : Byte-addressable little-endian data memory for an RV32I core.
//            Handles B/H/W/BU/HU loads and B/H/W stores via per-byte lane
//            enables. Each accepted request produces exactly one response
//            strobe READ_LATENCY cycles later. Illegal accesses (bad funct3,
//            unsigned store, misaligned H/W) answer with err=1 and change
//            nothing.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH        storage size in bytes (power of 2, >= 4)
//   READ_LATENCY cycles from accept to response (1..4)
// Ports
//   clk          clock; all state changes on its rising edge
//   reset        synchronous active-high reset (memory contents survive it)
//   req_valid    request present
//   req_ready    request can be accepted this cycle (idle and not in reset)
//   memwrite     1 = store, 0 = load
//   funct3       access type: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   address      byte address; bits above log2(DEPTH) are ignored (wrap)
//   writedata    store data, low bytes used
//   resp_valid   one-cycle response strobe
//   readdata     load result, zero unless resp_valid
//   err          illegal access flag, zero unless resp_valid
// ============================================================================
module datamem_bytelane #(
  parameter int DEPTH        = 64,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        memwrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  output logic        resp_valid,
  output logic [31:0] readdata,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  // WAIT lasts READ_LATENCY-1 cycles; the counter runs from this value to 0.
  localparam logic [1:0] WAIT_INIT = (READ_LATENCY >= 2) ? 2'(READ_LATENCY - 2) : 2'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  wait_cnt;

  logic [7:0]  mem [DEPTH];

  logic          accept;
  logic          illegal;
  logic [1:0]    offset;
  logic [AW-1:0] base;
  logic [31:0]   word;
  logic [31:0]   shifted;
  logic [31:0]   load_val;
  logic [31:0]   lane_data;
  logic [3:0]    lane_en;
  logic [31:0]   data_q;
  logic          err_q;
  logic          unused_addr;

  assign unused_addr = ^address[31:AW];

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // Every access lives inside one aligned word, so lane indices are formed
  // from the word base and never carry past the end of storage.
  assign offset = address[1:0];
  assign base   = address[AW-1:0] & ~AW'(3);

  always_comb begin
    illegal = 1'b0;
    if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
      illegal = 1'b1;
    if (memwrite && funct3[2])
      illegal = 1'b1;
    if (funct3[1:0] == 2'b01 && address[0])
      illegal = 1'b1;
    if (funct3 == 3'b010 && address[1:0] != 2'b00)
      illegal = 1'b1;
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign word[8*i +: 8] = mem[base | AW'(i)];
  end

  assign shifted = word >> {offset, 3'b000};

  always_comb begin
    load_val = '0;
    case (funct3)
      3'b000:  load_val = {{24{shifted[7]}},  shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_val = shifted;
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b101:  load_val = {16'd0, shifted[15:0]};
      default: load_val = '0;
    endcase
  end

  // Store data is moved onto its byte lanes; lane_en picks which lanes land.
  assign lane_data = writedata << {offset, 3'b000};

  always_comb begin
    lane_en = 4'b0000;
    case (funct3[1:0])
      2'b00:   lane_en = 4'b0001 << offset;
      2'b01:   lane_en = 4'b0011 << offset;
      2'b10:   lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
  end

  // Storage has no reset: contents persist across reset assertion.
  always_ff @(posedge clk) begin
    if (accept && memwrite && !illegal) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i])
          mem[base | AW'(i)] <= lane_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= 2'd0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        wait_cnt <= WAIT_INIT;
        // Load bytes are sampled now; a store in flight cannot disturb them.
        data_q   <= (illegal || memwrite) ? 32'd0 : load_val;
        err_q    <= illegal;
      end else if (state == WAIT && wait_cnt != 2'd0) begin
        wait_cnt <= wait_cnt - 2'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (READ_LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (wait_cnt == 2'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign resp_valid = (state == RESP);
  assign readdata   = (state == RESP) ? data_q : 32'd0;
  assign err        = (state == RESP) ? err_q  : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_datamem_bytelane.sv
`default_nettype none
// ============================================================================
// Module   : tb_datamem_bytelane
// Purpose  : Self-checking bench for datamem_bytelane. Three instances with
//            READ_LATENCY 2, 1 and 4 share request fields and reset; each has
//            its own req_valid. Expected results come from a vector table and
//            are queued when a request is driven, then popped on response.
// Revision : 1.0 - initial release
// ============================================================================
module tb_datamem_bytelane;

  localparam int LAT [3] = '{2, 1, 4};

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] writedata;
  logic        vld [3];
  logic        rdy [3];
  logic        rsp [3];
  logic [31:0] rdd [3];
  logic        er  [3];

  always #5 clk = ~clk;

  datamem_bytelane #(.DEPTH(64), .READ_LATENCY(2)) u_dut_l2 (
    .clk(clk), .reset(reset), .req_valid(vld[0]), .req_ready(rdy[0]),
    .memwrite(memwrite), .funct3(funct3), .address(address), .writedata(writedata),
    .resp_valid(rsp[0]), .readdata(rdd[0]), .err(er[0]));

  datamem_bytelane #(.DEPTH(64), .READ_LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset(reset), .req_valid(vld[1]), .req_ready(rdy[1]),
    .memwrite(memwrite), .funct3(funct3), .address(address), .writedata(writedata),
    .resp_valid(rsp[1]), .readdata(rdd[1]), .err(er[1]));

  datamem_bytelane #(.DEPTH(64), .READ_LATENCY(4)) u_dut_l4 (
    .clk(clk), .reset(reset), .req_valid(vld[2]), .req_ready(rdy[2]),
    .memwrite(memwrite), .funct3(funct3), .address(address), .writedata(writedata),
    .resp_valid(rsp[2]), .readdata(rdd[2]), .err(er[2]));

  typedef struct {
    logic        mw;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] d;
    logic        e;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t sb [$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One complete request/response on instance k, checking ready, latency,
  // busy window, response payload and the quiet outputs afterwards.
  task automatic xact(input int k, input vec_t v, input string nm);
    exp_t e;
    int   n;
    logic busy_bad;
    n = 0;
    while (rdy[k] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " ready"}, 32'(rdy[k]), 32'd1);
    memwrite  = v.mw;
    funct3    = v.f3;
    address   = v.a;
    writedata = v.wd;
    vld[k]    = 1'b1;
    sb.push_back('{d: v.d, e: v.e});
    @(negedge clk);
    // Fields must have been captured at accept; scramble them now.
    vld[k]    = 1'b0;
    memwrite  = 1'($urandom);
    funct3    = 3'($urandom);
    address   = $urandom;
    writedata = $urandom;
    n = 1;
    busy_bad = 1'b0;
    while (rsp[k] !== 1'b1 && n < 12) begin
      if (rdy[k] !== 1'b0) busy_bad = 1'b1;
      @(negedge clk);
      n++;
    end
    if (rdy[k] !== 1'b0) busy_bad = 1'b1;
    chk({nm, " latency"}, 32'(n), 32'(LAT[k]));
    chk({nm, " ready low while busy"}, 32'(busy_bad), 32'd0);
    e = sb.pop_front();
    if (rsp[k] === 1'b1) begin
      chk({nm, " readdata"}, rdd[k], e.d);
      chk({nm, " err"}, 32'(er[k]), 32'(e.e));
    end else begin
      chk({nm, " response timeout"}, 32'(rsp[k]), 32'd1);
    end
    @(negedge clk);
    chk({nm, " quiet after resp"}, {rdd[k][30:0], rsp[k]}, 32'd0);
    chk({nm, " err quiet after resp"}, {31'd0, er[k]} | {31'd0, rdd[k][31]}, 32'd0);
  endtask

  vec_t tbl [20];

  initial begin
    int   nvec;
    logic seen;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   nvec;
    logic seen;
    vec_t v;

    tbl[0]  = '{1'b1, 3'b010, 32'h08, 32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 3'b010, 32'h08, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b0, 3'b000, 32'h08, 32'h0,        32'hFFFFFFEF, 1'b0};
    tbl[3]  = '{1'b0, 3'b100, 32'h0B, 32'h0,        32'h000000DE, 1'b0};
    tbl[4]  = '{1'b0, 3'b001, 32'h0A, 32'h0,        32'hFFFFDEAD, 1'b0};
    tbl[5]  = '{1'b0, 3'b101, 32'h08, 32'h0,        32'h0000BEEF, 1'b0};
    tbl[6]  = '{1'b1, 3'b000, 32'h09, 32'h12345655, 32'h0,        1'b0};
    tbl[7]  = '{1'b0, 3'b010, 32'h08, 32'h0,        32'hDEAD55EF, 1'b0};
    tbl[8]  = '{1'b0, 3'b010, 32'h06, 32'h0,        32'h0,        1'b1};
    tbl[9]  = '{1'b1, 3'b010, 32'h00, 32'h11223344, 32'h0,        1'b0};
    tbl[10] = '{1'b1, 3'b001, 32'h03, 32'hAAAAAAAA, 32'h0,        1'b1};
    tbl[11] = '{1'b0, 3'b010, 32'h00, 32'h0,        32'h11223344, 1'b0};
    tbl[12] = '{1'b0, 3'b011, 32'h00, 32'h0,        32'h0,        1'b1};
    tbl[13] = '{1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0,        1'b0};
    tbl[14] = '{1'b0, 3'b010, 32'h00, 32'h0,        32'hCAFEF00D, 1'b0};
    tbl[15] = '{1'b1, 3'b100, 32'h00, 32'hFFFFFFFF, 32'h0,        1'b1};
    tbl[16] = '{1'b0, 3'b010, 32'h00, 32'h0,        32'hCAFEF00D, 1'b0};
    tbl[17] = '{1'b0, 3'b001, 32'h09, 32'h0,        32'h0,        1'b1};
    tbl[18] = '{1'b1, 3'b001, 32'h7E, 32'hBEEF8001, 32'h0,        1'b0};
    tbl[19] = '{1'b0, 3'b001, 32'h3E, 32'h0,        32'hFFFF8001, 1'b0};
    nvec = 20;

    reset     = 1'b1;
    memwrite  = 1'b0;
    funct3    = 3'b000;
    address   = 32'd0;
    writedata = 32'd0;
    for (int i = 0; i < 3; i++) vld[i] = 1'b0;
    repeat (3) @(negedge clk);

    chk("reset ready L2", 32'(rdy[0]), 32'd0);
    chk("reset ready L4", 32'(rdy[2]), 32'd0);
    chk("reset resp_valid", 32'(rsp[0]), 32'd0);
    chk("reset readdata", rdd[0], 32'd0);
    chk("reset err", 32'(er[0]), 32'd0);

    reset = 1'b0;
    #1;
    chk("ready after reset", 32'(rdy[0]), 32'd1);
    @(negedge clk);

    for (int i = 0; i < nvec; i++)
      xact(0, tbl[i], $sformatf("vec%0d", i));

    // Extra lookup on the halfword just stored near the top of storage.
    v = '{1'b0, 3'b101, 32'h3E, 32'h0, 32'h00008001, 1'b0};
    xact(0, v, "lhu top");
    v = '{1'b0, 3'b000, 32'h09, 32'h0, 32'h00000055, 1'b0};
    xact(0, v, "lb positive");

    // Reset while a load sits in WAIT: its response must never appear.
    while (rdy[0] !== 1'b1) @(negedge clk);
    memwrite = 1'b0; funct3 = 3'b010; address = 32'h08; vld[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    chk("wait no early resp", 32'(rsp[0]), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("ready low in reset", 32'(rdy[0]), 32'd0);
    reset = 1'b0;
    #1;
    chk("ready after mid reset", 32'(rdy[0]), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp[0] === 1'b1) seen = 1'b1;
    end
    chk("dropped resp after reset", 32'(seen), 32'd0);
    v = '{1'b0, 3'b010, 32'h08, 32'h0, 32'hDEAD55EF, 1'b0};
    xact(0, v, "store survives reset");

    // Latency 1 and 4 instances.
    for (int k = 1; k < 3; k++) begin
      v = '{1'b1, 3'b010, 32'h08, 32'hDEADBEEF, 32'h0, 1'b0};
      xact(k, v, $sformatf("L%0d sw", LAT[k]));
      v = '{1'b0, 3'b010, 32'h08, 32'h0, 32'hDEADBEEF, 1'b0};
      xact(k, v, $sformatf("L%0d lw", LAT[k]));
    end

    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/datamem_bytelane.md
DATAMEM_BYTELANE -- requirements
Module: datamem_bytelane

Interface
REQ-001 SHALL have parameter DEPTH, default 64, storage size in bytes (power of 2, >= 4).
REQ-002 SHALL have parameter READ_LATENCY, default 1, cycles from request accept to response (legal range 1..4).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  block can accept a request this cycle.
REQ-007 SHALL have port memwrite  input  1  1 = store, 0 = load.
REQ-008 SHALL have port funct3  input  3  RV32I access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 SHALL have port address  input  32  byte address.
REQ-010 SHALL have port writedata  input  32  store data, taken from the low bytes.
REQ-011 SHALL have port resp_valid  output  1  one-cycle response strobe.
REQ-012 SHALL have port readdata  output  32  load result; valid only while resp_valid=1.
REQ-013 SHALL have port err  output  1  access rejected; valid only while resp_valid=1.

Function
REQ-014 SHALL store DEPTH bytes little-endian; byte index = address[log2(DEPTH)-1:0], so upper address bits wrap.
REQ-015 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; req_ready=1 only in IDLE.
REQ-016 SHALL accept a request on a cycle with req_valid=1 and req_ready=1 (cycle N).
REQ-017 SHALL assert resp_valid for exactly one cycle, in cycle N+READ_LATENCY (RESP state); WAIT lasts READ_LATENCY-1 cycles (skipped when 1).
REQ-018 SHALL give one response per accepted request, loads and stores alike; max throughput is one request per READ_LATENCY+1 cycles.
REQ-019 SHALL ignore req_valid, memwrite, funct3, address and writedata outside the accept cycle; request fields are captured at accept.
REQ-020 SHALL flag an access illegal when any of these holds: funct3 = 011, 110 or 111; store with funct3[2]=1; H/HU with address[0]=1; W with address[1:0]!=00.
REQ-021 SHALL commit a legal store at the rising edge ending cycle N, writing only the selected bytes: B = 1 byte, H = 2 bytes, W = 4 bytes.
REQ-022 SHALL leave memory unmodified on an illegal store.
REQ-023 SHALL sample load bytes at accept; a load accepted after a store's response returns the stored data.
REQ-024 SHALL sign-extend B/H loads and zero-extend BU/HU loads to 32 bits.
REQ-025 SHALL drive err=1 and readdata=0 for an illegal request.
REQ-026 SHALL drive err=0 for a legal request, with readdata=0 for any store.
REQ-027 SHALL hold readdata=0 and err=0 whenever resp_valid=0.
REQ-028 SHALL keep an access within one aligned word; a misaligned access never wraps across the end of storage.

Reset
REQ-029 SHALL, while reset=1 at a rising edge, force state IDLE, resp_valid=0, readdata=0 and err=0.
REQ-030 SHALL hold req_ready=0 while reset=1 and assert it in the first cycle after reset deasserts.
REQ-031 SHALL, when reset hits in WAIT or RESP, drop the pending response: no later resp_valid for that request.
REQ-032 SHALL NOT clear memory contents on reset; a store committed before reset persists.
REQ-033 SHALL treat memory contents as undefined at power-up.

Verification (DEPTH=64, READ_LATENCY=2 unless stated)
REQ-034 SW 0xDEADBEEF @0x08, then LW @0x08 -> resp_valid exactly 2 cycles after accept, readdata=0xDEADBEEF, err=0.
REQ-035 Following REQ-034 -> LB @0x08=0xFFFFFFEF; LBU @0x0B=0x000000DE; LH @0x0A=0xFFFFDEAD; LHU @0x08=0x0000BEEF.
REQ-036 SB 0x12345655 @0x09, then LW @0x08 -> 0xDEAD55EF.
REQ-037 LW @0x06 -> err=1, readdata=0; SH @0x03 -> err=1, then LW @0x00 shows the word unchanged; funct3=011 -> err=1.
REQ-038 Address wrap: SW 0xCAFEF00D @0x40, then LW @0x00 -> 0xCAFEF00D.
REQ-039 LW accepted, reset pulsed for 1 cycle in WAIT -> no resp_valid for that LW; req_ready=1 the cycle after reset drops; earlier stores are still readable.
REQ-040 Repeat REQ-034 with READ_LATENCY=1 and with READ_LATENCY=4 -> latency 1 and 4 respectively; req_ready=0 from N+1 through N+READ_LATENCY.
